// File: rtl/pe_mem_req_arbiter.sv
// Round-robin, burst-locked arbiter for the PE memory request port.
// Optional PE_MEM_ARB_PERF_CNT_EN adds grant and stall counters.
module pe_mem_req_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_W    = 24,
  parameter int DATA_W    = 32,
  parameter int BURST_W   = 4,
  parameter int RSP_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset_poweron,
  input  logic [NUM_REQ-1:0]         req__valid,
  input  logic [NUM_REQ-1:0]         req__write,
  input  logic [NUM_REQ*ADDR_W-1:0]  req__addr,
  input  logic [NUM_REQ*DATA_W-1:0]  req__wdata,
  input  logic [NUM_REQ*BURST_W-1:0] req__burst_len,
  output logic [NUM_REQ-1:0]         req__ready,
  output logic                       mem__valid,
  output logic                       mem__write,
  output logic [ADDR_W-1:0]          mem__addr,
  output logic [DATA_W-1:0]          mem__wdata,
  input  logic                       mem__ready,
  input  logic                       mem__rvalid,
  input  logic [DATA_W-1:0]          mem__rdata,
  output logic [NUM_REQ-1:0]         rsp__valid,
  output logic [DATA_W-1:0]          rsp__data,
`ifdef PE_MEM_ARB_PERF_CNT_EN
  output logic [NUM_REQ*16-1:0]      perf__grant_cnt,
  output logic [15:0]                perf__stall_cnt,
`endif
  output logic                       arb__err
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  typedef logic [IDX_W-1:0] idx_t;
  typedef enum logic {IDLE, BURST} state_t;

  state_t              state, state_nxt;
  idx_t                owner, owner_nxt;
  idx_t                rr_ptr, rr_nxt;
  logic [BURST_W-1:0]  beat_cnt, cnt_nxt;

  logic [ADDR_W-1:0]   addr_a  [NUM_REQ];
  logic [DATA_W-1:0]   wdata_a [NUM_REQ];
  logic [BURST_W-1:0]  len_a   [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_a[g]  = req__addr[g*ADDR_W +: ADDR_W];
    assign wdata_a[g] = req__wdata[g*DATA_W +: DATA_W];
    assign len_a[g]   = req__burst_len[g*BURST_W +: BURST_W];
  end

  logic          in_burst;
  logic          own_valid;
  logic          own_write;
  logic          rd_block;
  logic          beat_acc;
  logic          grant;
  logic          pick_vld;
  idx_t          pick;
  idx_t          owner_inc;

  logic          push, pop;
  logic          fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_cnt;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  idx_t          tag_mem [RSP_DEPTH];
  idx_t          head_tag;

  assign in_burst  = (state == BURST);
  assign own_valid = req__valid[owner];
  assign own_write = req__write[owner];
  assign fifo_full  = (fifo_cnt == CNT_W'(RSP_DEPTH));
  assign fifo_empty = (fifo_cnt == '0);

  // Full is judged on the registered count, so a same-cycle pop
  // never frees room for a read beat.
  assign rd_block = ~own_write & fifo_full;
  assign beat_acc = in_burst & own_valid & ~rd_block & mem__ready;

  assign owner_inc = (owner == idx_t'(NUM_REQ - 1)) ?
                     '0 : owner + 1'b1;

  always_comb begin
    pick_vld = 1'b0;
    pick     = rr_ptr;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      int j;
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (req__valid[j]) begin
        pick_vld = 1'b1;
        pick     = idx_t'(j);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      state    <= IDLE;
      owner    <= '0;
      rr_ptr   <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      owner    <= owner_nxt;
      rr_ptr   <= rr_nxt;
      beat_cnt <= cnt_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    owner_nxt  = owner;
    rr_nxt     = rr_ptr;
    cnt_nxt    = beat_cnt;
    grant      = 1'b0;
    req__ready = '0;
    mem__valid = 1'b0;
    mem__write = 1'b0;
    mem__addr  = '0;
    mem__wdata = '0;
    unique case (state)
      IDLE: begin
        if (pick_vld) begin
          grant     = 1'b1;
          owner_nxt = pick;
          cnt_nxt   = len_a[pick];
          state_nxt = BURST;
        end
      end
      BURST: begin
        mem__valid        = own_valid & ~rd_block;
        mem__write        = own_write;
        mem__addr         = addr_a[owner];
        mem__wdata        = wdata_a[owner];
        req__ready[owner] = mem__ready & ~rd_block;
        if (beat_acc) begin
          if (beat_cnt == '0) begin
            state_nxt = IDLE;
            rr_nxt    = owner_inc;
          end else begin
            cnt_nxt = beat_cnt - 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign push     = beat_acc & ~own_write;
  assign pop      = mem__rvalid & ~fifo_empty;
  assign head_tag = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
      arb__err <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
        2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
        default: fifo_cnt <= fifo_cnt;
      endcase
      if (mem__rvalid & fifo_empty) arb__err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= owner;
  end

  always_comb begin
    rsp__valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp__valid[i] = pop & (head_tag == idx_t'(i));
    end
  end

  assign rsp__data = mem__rdata;

`ifdef PE_MEM_ARB_PERF_CNT_EN
  logic [15:0] grant_cnt [NUM_REQ];
  logic        stall_cyc;

  assign stall_cyc = in_burst & own_valid & ~req__ready[owner];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_perf
    assign perf__grant_cnt[g*16 +: 16] = grant_cnt[g];

    always_ff @(posedge clk) begin
      if (reset_poweron) begin
        grant_cnt[g] <= '0;
      end else if (grant && pick == idx_t'(g) &&
                   grant_cnt[g] != 16'hFFFF) begin
        grant_cnt[g] <= grant_cnt[g] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset_poweron) begin
      perf__stall_cnt <= '0;
    end else if (stall_cyc && perf__stall_cnt != 16'hFFFF) begin
      perf__stall_cnt <= perf__stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pe_mem_req_arbiter.sv
// Directed bench for pe_mem_req_arbiter: grant, lock,
// tag FIFO, response routing, error and reset behaviour.
module tb_pe_mem_req_arbiter;

  localparam int NR = 4;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int BW = 4;

  logic           clk = 1'b0;
  logic           reset_poweron;
  logic [NR-1:0]  req__valid;
  logic [NR-1:0]  req__write;
  logic [NR*AW-1:0] req__addr;
  logic [NR*DW-1:0] req__wdata;
  logic [NR*BW-1:0] req__burst_len;
  logic [NR-1:0]  req__ready;
  logic           mem__valid;
  logic           mem__write;
  logic [AW-1:0]  mem__addr;
  logic [DW-1:0]  mem__wdata;
  logic           mem__ready;
  logic           mem__rvalid;
  logic [DW-1:0]  mem__rdata;
  logic [NR-1:0]  rsp__valid;
  logic [DW-1:0]  rsp__data;
  logic           arb__err;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pe_mem_req_arbiter dut (
    .clk            (clk),
    .reset_poweron  (reset_poweron),
    .req__valid     (req__valid),
    .req__write     (req__write),
    .req__addr      (req__addr),
    .req__wdata     (req__wdata),
    .req__burst_len (req__burst_len),
    .req__ready     (req__ready),
    .mem__valid     (mem__valid),
    .mem__write     (mem__write),
    .mem__addr      (mem__addr),
    .mem__wdata     (mem__wdata),
    .mem__ready     (mem__ready),
    .mem__rvalid    (mem__rvalid),
    .mem__rdata     (mem__rdata),
    .rsp__valid     (rsp__valid),
    .rsp__data      (rsp__data),
    .arb__err       (arb__err)
  );

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_poweron = 1'b1;
    req__valid    = '0;
    mem__rvalid   = 1'b0;
    tick();
    reset_poweron = 1'b0;
    #1;
  endtask

  task automatic single_read(input int idx);
    req__valid      = '0;
    req__valid[idx] = 1'b1;
    req__write      = '0;
    req__burst_len  = '0;
    tick();
    tick();
    req__valid = '0;
  endtask

  logic [NR-1:0] exp_v;
  logic [NR-1:0] rsp_seq [3];

  initial begin
    reset_poweron  = 1'b1;
    req__valid     = '0;
    req__write     = '0;
    req__addr      = '0;
    req__wdata     = '0;
    req__burst_len = '0;
    mem__ready     = 1'b0;
    mem__rvalid    = 1'b0;
    mem__rdata     = '0;
    tick();
    tick();
    reset_poweron = 1'b0;
    #1;
    chk("rst ready", req__ready, 4'b0000);
    chk("rst mem_valid", mem__valid, 1'b0);
    chk("rst rsp_valid", rsp__valid, 4'b0000);
    chk("rst err", arb__err, 1'b0);
    chk("rst rr_ptr", dut.rr_ptr, 2'd0);
    chk("rst fifo", dut.fifo_cnt, 4'd0);

    mem__ready          = 1'b1;
    req__valid          = 4'b0010;
    req__write          = 4'b0000;
    req__burst_len[7:4] = 4'd3;
    req__addr[AW +: AW] = 24'h000100;
    #1;
    chk("t1 idle ready", req__ready, 4'b0000);
    chk("t1 idle mvalid", mem__valid, 1'b0);
    tick();
    chk("t1 owner", dut.owner, 2'd1);
    for (int b = 0; b < 4; b++) begin
      req__addr[AW +: AW] = 24'h000100 + 24'(b);
      #1;
      chk("t1 beat mvalid", mem__valid, 1'b1);
      chk("t1 beat ready", req__ready, 4'b0010);
      chk("t1 beat addr", mem__addr, 24'h000100 + 24'(b));
      tick();
    end
    req__valid = '0;
    #1;
    chk("t1 back idle", dut.in_burst, 1'b0);
    chk("t1 rr_ptr", dut.rr_ptr, 2'd2);
    chk("t1 fifo", dut.fifo_cnt, 4'd4);
    for (int r = 0; r < 4; r++) begin
      mem__rvalid = 1'b1;
      mem__rdata  = 32'hA000_0000 + 32'(r);
      #1;
      chk("t1 rsp valid", rsp__valid, 4'b0010);
      chk("t1 rsp data", rsp__data, 32'hA000_0000 + 32'(r));
      tick();
    end
    mem__rvalid = 1'b0;
    #1;
    chk("t1 fifo drained", dut.fifo_cnt, 4'd0);
    chk("t1 no err", arb__err, 1'b0);

    do_reset();
    req__valid     = 4'hF;
    req__write     = 4'hF;
    req__burst_len = '0;
    for (int g = 0; g < 5; g++) begin
      exp_v = 4'b0001 << (g % 4);
      tick();
      chk("rr grant", req__ready, exp_v);
      chk("rr write", mem__write, 1'b1);
      tick();
    end
    req__valid = '0;

    do_reset();
    req__valid           = 4'b0001;
    req__write           = 4'hF;
    req__burst_len[3:0]  = 4'd7;
    req__burst_len[11:8] = 4'd0;
    tick();
    for (int b = 0; b < 3; b++) begin
      chk("lock beat ready", req__ready, 4'b0001);
      chk("lock beat mvalid", mem__valid, 1'b1);
      tick();
    end
    req__valid          = 4'b0100;
    req__burst_len[3:0] = 4'd0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("lock gap mvalid", mem__valid, 1'b0);
      chk("lock gap ready", req__ready, 4'b0001);
      tick();
    end
    req__valid = 4'b0101;
    for (int b = 3; b < 8; b++) begin
      #1;
      chk("lock tail ready", req__ready, 4'b0001);
      chk("lock tail owner", dut.owner, 2'd0);
      tick();
    end
    req__valid = 4'b0100;
    #1;
    chk("lock idle", dut.in_burst, 1'b0);
    tick();
    chk("lock req2 grant", req__ready, 4'b0100);
    tick();
    req__valid = '0;

    do_reset();
    req__valid          = 4'b0010;
    req__write          = 4'b0000;
    req__burst_len[7:4] = 4'd15;
    tick();
    for (int b = 0; b < 8; b++) begin
      chk("full accept ready", req__ready, 4'b0010);
      tick();
    end
    chk("full stall ready", req__ready, 4'b0000);
    chk("full stall mvalid", mem__valid, 1'b0);
    chk("full count", dut.fifo_cnt, 4'd8);
    tick();
    chk("full stall2 ready", req__ready, 4'b0000);
    mem__rvalid = 1'b1;
    mem__rdata  = 32'hDEAD_BEEF;
    #1;
    chk("full pop rsp", rsp__valid, 4'b0010);
    chk("full pop no bypass", req__ready, 4'b0000);
    tick();
    mem__rvalid = 1'b0;
    #1;
    chk("full 9th ready", req__ready, 4'b0010);
    chk("full 9th mvalid", mem__valid, 1'b1);
    chk("full count 7", dut.fifo_cnt, 4'd7);
    tick();
    chk("full count 8", dut.fifo_cnt, 4'd8);

    do_reset();
    mem__ready = 1'b1;
    single_read(3);
    single_read(0);
    single_read(3);
    #1;
    chk("il fifo", dut.fifo_cnt, 4'd3);
    rsp_seq[0] = 4'b1000;
    rsp_seq[1] = 4'b0001;
    rsp_seq[2] = 4'b1000;
    for (int i = 0; i < 3; i++) begin
      mem__rvalid = 1'b1;
      mem__rdata  = 32'h1111_0000 + 32'(i);
      #1;
      chk("il rsp valid", rsp__valid, rsp_seq[i]);
      chk("il rsp data", rsp__data, 32'h1111_0000 + 32'(i));
      tick();
    end
    mem__rdata = 32'h5555_5555;
    #1;
    chk("il spurious rsp", rsp__valid, 4'b0000);
    chk("il err not yet", arb__err, 1'b0);
    tick();
    mem__rvalid = 1'b0;
    #1;
    chk("il err set", arb__err, 1'b1);
    tick();
    tick();
    chk("il err sticky", arb__err, 1'b1);

    do_reset();
    chk("err cleared", arb__err, 1'b0);
    req__valid          = 4'b0010;
    req__write          = 4'b0000;
    req__burst_len[7:4] = 4'd4;
    tick();
    tick();
    chk("mid beat2 ready", req__ready, 4'b0010);
    chk("mid fifo 1", dut.fifo_cnt, 4'd1);
    reset_poweron = 1'b1;
    tick();
    reset_poweron = 1'b0;
    #1;
    chk("mid ready", req__ready, 4'b0000);
    chk("mid mvalid", mem__valid, 1'b0);
    chk("mid rsp", rsp__valid, 4'b0000);
    chk("mid fifo", dut.fifo_cnt, 4'd0);
    chk("mid owner", dut.owner, 2'd0);
    chk("mid rr_ptr", dut.rr_ptr, 2'd0);
    chk("mid idle", dut.in_burst, 1'b0);
    req__valid = '0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/pe_mem_req_arbiter.md
Name: pe_mem_req_arbiter

Overview:
- Shares the single PE memory-controller request port between NUM_REQ requesters: DMA, load/store unit, scalar regfile spill and lane regfile spill.
- Uses round-robin arbitration with burst lock, so a granted requester keeps the port until its burst completes.
- Routes in-order read responses back to the issuing requester through an internal tag FIFO.
- Sits between the PE-side requesters and the memory controller, inside the PE.

Parameters:
- NUM_REQ, 4, number of requesters; requester index 0 is the DMA.
- ADDR_W, 24, memory word-address width.
- DATA_W, 32, data width per beat.
- BURST_W, 4, width of the burst-length field, encoded as beats-1 (max 16 beats).
- RSP_DEPTH, 8, read-tag FIFO depth; power of 2.

Ports:
- clk  in  1  clock.
- reset_poweron  in  1  synchronous, active-high reset.
- req__valid  in  NUM_REQ  per-requester beat valid.
- req__write  in  NUM_REQ  1 = write beat, 0 = read beat.
- req__addr  in  NUM_REQ*ADDR_W  beat address, packed with requester i at bits [i*ADDR_W +: ADDR_W].
- req__wdata  in  NUM_REQ*DATA_W  write data, packed the same way.
- req__burst_len  in  NUM_REQ*BURST_W  beats-1; sampled on the first beat of a burst only.
- req__ready  out  NUM_REQ  beat accepted when valid & ready.
- mem__valid  out  1  beat valid to the memory controller.
- mem__write  out  1  write flag to the memory controller.
- mem__addr  out  ADDR_W  address to the memory controller.
- mem__wdata  out  DATA_W  write data to the memory controller.
- mem__ready  in  1  memory controller accepts the beat.
- mem__rvalid  in  1  read data returning, in issue order.
- mem__rdata  in  DATA_W  returned read data.
- rsp__valid  out  NUM_REQ  one-hot read-response strobe.
- rsp__data  out  DATA_W  read data, broadcast to all requesters.
- arb__err  out  1  sticky protocol error flag.

Behaviour:
- Reset values:
  - state=IDLE, owner=0, rr_ptr=0 (highest priority goes to index 0 first), beat_cnt=0.
  - Tag FIFO empty; arb__err=0.
  - All outputs 0: req__ready, mem__valid, rsp__valid.
- State machine, IDLE:
  - req__ready=0 and mem__valid=0.
  - If any req__valid is high, select the first asserted index searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Register that index as owner, load beat_cnt from its req__burst_len, and go to BURST.
  - Arbitration costs exactly one cycle; the first beat can be accepted on the next cycle.
- State machine, BURST:
  - mem__valid/write/addr/wdata pass through combinationally from the owner.
  - req__ready[owner] = mem__ready & ~(read beat & tag_fifo_full); all other ready bits are 0.
  - mem__valid is forced to 0 when the owner's beat is a read and the tag FIFO is full.
  - On each accepted beat: if beat_cnt==0, go to IDLE and set rr_ptr=owner+1 (wrapping); otherwise decrement beat_cnt.
- Burst lock:
  - The burst-length field is ignored after the burst is locked.
  - If the owner drops req__valid mid-burst, the arbiter waits; it never pre-empts.
  - Mixed read and write beats within one burst are legal.
- Tag FIFO:
  - Push the owner index on every accepted read beat.
  - On mem__rvalid: pop, assert rsp__valid[tag] for that same cycle (combinational from FIFO head), and set rsp__data=mem__rdata.
  - Push and pop in the same cycle are allowed, and the occupancy count is unchanged.
  - Full is evaluated on the registered count; no bypass when a pop coincides, which is conservative.
- Errors:
  - mem__rvalid with an empty FIFO sets arb__err; rsp__valid stays 0.
  - arb__err clears only on reset.
- Reset mid-burst:
  - Abandons the burst and flushes the FIFO.
  - Outstanding memory responses after reset are the memory controller's responsibility.
- Requester latency: the owner sees ready in the same cycle as mem__ready.

Optional Feature:
- PE_MEM_ARB_PERF_CNT_EN
- When defined:
  - Adds an output perf__grant_cnt of width NUM_REQ*16: one counter per requester, incrementing on each IDLE->BURST grant and saturating at 16'hFFFF.
  - Adds an output perf__stall_cnt of width 16: counts BURST cycles where the owner is valid but not ready, saturating.
  - Both counters reset to 0.
- When undefined: the ports and logic are absent, and all other behaviour is identical.

Test Plan:
- Single request: req 1 raises a read with burst_len=3 and mem__ready held at 1. Required: grant in cycle 1, 4 beats in cycles 2-5, return to IDLE, rr_ptr=2, four rsp__valid[1] pulses as mem__rvalid returns.
- Round-robin fairness: all 4 requesters continuously request single-beat writes. Required grant order 0,1,2,3,0; no requester is granted twice before all others.
- Burst lock: req 0 has an 8-beat burst and req 2 raises valid mid-burst while req 0 deasserts valid for 3 cycles. Required: req 2 is not granted until req 0's 8th beat is accepted.
- Tag FIFO full: 9 reads with mem__rvalid held low. Required: 8 reads accepted, the 9th stalls (ready=0, mem__valid=0); one mem__rvalid then returns the oldest tag and the 9th read is accepted the next cycle.
- Interleaved responses: reads from requesters 3, 0, 3. Required: rsp__valid sequence 4'b1000, 4'b0001, 4'b1000 with matching data; then a spurious mem__rvalid sets arb__err=1.
- Reset mid-burst: reset_poweron=1 for 1 cycle during beat 2 of a 5-beat burst. Required: all outputs 0 next cycle, FIFO empty, owner=0, rr_ptr=0.
